// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and the forwarding unit.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW_DEF       = 5;
  localparam int unsigned CNT_W_DEF        = 32;
  localparam int unsigned DMEM_TIMEOUT_DEF = 255;

  // Hazard priority, 1 = highest. The forwarding unit uses the same ordering.
  localparam int unsigned PRIO_DMEM    = 1;
  localparam int unsigned PRIO_BRANCH  = 2;
  localparam int unsigned PRIO_LOADUSE = 3;
  localparam int unsigned PRIO_IMEM    = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DWAIT = 1'b1
  } ctrl_state_e;

  // Which rule won this cycle; encoding equals the priority rank.
  typedef enum logic [2:0] {
    HZ_NONE    = 3'd0,
    HZ_DMEM    = 3'(PRIO_DMEM),
    HZ_BRANCH  = 3'(PRIO_BRANCH),
    HZ_LOADUSE = 3'(PRIO_LOADUSE),
    HZ_IMEM    = 3'(PRIO_IMEM)
  } hazard_e;

  // One bundle of all pipeline-register controls.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_write;
    logic memwb_flush;
  } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline status inputs, register controls and counters of the hazard controller.
//
// Control contract: a stage register holds when its Write is 0 and loads when it is 1.
// A Flush replaces the loaded value by a bubble and only acts together with Write=1
// (IF_IDFlush) or as a bubble insert at the register input (ID_EXFlush, MEM_WBFlush).
// All controls are combinational in the same cycle as the status that causes them.
interface pipeline_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic [REG_AW-1:0] ID_rs1;
  logic [REG_AW-1:0] ID_rs2;
  logic              ID_UsesRs1;
  logic              ID_UsesRs2;
  logic [REG_AW-1:0] EX_rd;
  logic              EX_MemRead;
  logic              EX_BranchTaken;
  logic              MEM_MemReq;
  logic              MEM_MemReady;
  logic              IF_ImemReady;

  logic              PCWrite;
  logic              IF_IDWrite;
  logic              IF_IDFlush;
  logic              ID_EXWrite;
  logic              ID_EXFlush;
  logic              EX_MEMWrite;
  logic              MEM_WBWrite;
  logic              MEM_WBFlush;
  logic [CNT_W-1:0]  StallCycles;
  logic [CNT_W-1:0]  FlushCount;
  logic              DmemTimeoutErr;

  ctrl_state_e       dbg_state;
  hazard_e           dbg_hazard;

  modport master (
    output ID_rs1, ID_rs2, ID_UsesRs1, ID_UsesRs2, EX_rd, EX_MemRead,
           EX_BranchTaken, MEM_MemReq, MEM_MemReady, IF_ImemReady,
    input  PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush,
           EX_MEMWrite, MEM_WBWrite, MEM_WBFlush, StallCycles, FlushCount,
           DmemTimeoutErr, dbg_state, dbg_hazard
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_UsesRs1, ID_UsesRs2, EX_rd, EX_MemRead,
           EX_BranchTaken, MEM_MemReq, MEM_MemReady, IF_ImemReady,
    output PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush,
           EX_MEMWrite, MEM_WBWrite, MEM_WBFlush, StallCycles, FlushCount,
           DmemTimeoutErr, dbg_state, dbg_hazard
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count up on i_inc until all-ones, then hold.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: data-memory waits, branch
// redirects, load-use bubbles and instruction-memory waits, plus counters and
// a data-memory wait watchdog.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);

  ctrl_state_e       r_state;
  ctrl_state_e       w_state_nxt;
  ctrl_t             w_ctrl;
  hazard_e           w_hazard;
  logic              w_dmem_stall;
  logic              w_load_use;
  logic [REG_AW-1:0] w_ex_rd;
  logic [WAIT_W-1:0] w_wait_cnt;
  logic              r_err;

  assign w_ex_rd      = bus.EX_rd;
  assign w_dmem_stall = bus.MEM_MemReq & ~bus.MEM_MemReady;
  // x0 is never a real dependency, so a load to x0 never stalls.
  assign w_load_use   = bus.EX_MemRead && (w_ex_rd != '0) &&
                        ((bus.ID_UsesRs1 && (bus.ID_rs1 == w_ex_rd)) ||
                         (bus.ID_UsesRs2 && (bus.ID_rs2 == w_ex_rd)));

  // State register for the data-memory wait FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the priority-resolved stage controls.
  always_comb begin
    w_state_nxt = r_state;
    w_hazard    = HZ_NONE;
    w_ctrl      = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                    idex_write: 1'b1, idex_flush: 1'b0, exmem_write: 1'b1,
                    memwb_write: 1'b1, memwb_flush: 1'b0};

    case (r_state)
      ST_RUN:   if (w_dmem_stall) w_state_nxt = ST_DWAIT;
      ST_DWAIT: if (bus.MEM_MemReady) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase

    if (w_dmem_stall) begin
      // Freeze everything up to EX/MEM; a pending branch re-resolves after release.
      w_hazard           = HZ_DMEM;
      w_ctrl.pc_write    = 1'b0;
      w_ctrl.ifid_write  = 1'b0;
      w_ctrl.idex_write  = 1'b0;
      w_ctrl.exmem_write = 1'b0;
      w_ctrl.memwb_flush = 1'b1;
    end else if (bus.EX_BranchTaken) begin
      // Redirect wins over an imem wait; the squashed younger op cannot cause load-use.
      w_hazard          = HZ_BRANCH;
      w_ctrl.ifid_flush = 1'b1;
      w_ctrl.idex_flush = 1'b1;
    end else if (w_load_use) begin
      w_hazard          = HZ_LOADUSE;
      w_ctrl.pc_write   = 1'b0;
      w_ctrl.ifid_write = 1'b0;
      w_ctrl.idex_flush = 1'b1;
    end else if (!bus.IF_ImemReady) begin
      w_hazard          = HZ_IMEM;
      w_ctrl.pc_write   = 1'b0;
      w_ctrl.ifid_flush = 1'b1;
    end

    if (reset) begin
      w_ctrl = '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (1'b0),
    .i_inc   (~w_ctrl.pc_write),
    .o_count (bus.StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (1'b0),
    .i_inc   (w_hazard == HZ_BRANCH),
    .o_count (bus.FlushCount)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state == ST_RUN),
    .i_inc   (r_state == ST_DWAIT),
    .o_count (w_wait_cnt)
  );

  // Sticky watchdog: set on the edge where the wait count reaches the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_DWAIT) && (w_wait_cnt >= WAIT_LAST)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.PCWrite        = w_ctrl.pc_write;
  assign bus.IF_IDWrite     = w_ctrl.ifid_write;
  assign bus.IF_IDFlush     = w_ctrl.ifid_flush;
  assign bus.ID_EXWrite     = w_ctrl.idex_write;
  assign bus.ID_EXFlush     = w_ctrl.idex_flush;
  assign bus.EX_MEMWrite    = w_ctrl.exmem_write;
  assign bus.MEM_WBWrite    = w_ctrl.memwb_write;
  assign bus.MEM_WBFlush    = w_ctrl.memwb_flush;
  assign bus.DmemTimeoutErr = r_err;
  assign bus.dbg_state      = r_state;
  assign bus.dbg_hazard     = w_hazard;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random traffic.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;
  localparam int TMO    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .DMEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  logic        m_dwait = 1'b0;
  int          m_wait  = 0;
  logic        m_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Control vector order: {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite,
  //                        ID_EXFlush, EX_MEMWrite, MEM_WBWrite, MEM_WBFlush}
  function automatic logic [7:0] model_ctrl(
    input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic u1, input logic u2, input logic [4:0] exrd, input logic mr,
    input logic br, input logic req, input logic rdy, input logic imem);
    logic lu;
    lu = mr && (exrd != 5'd0) && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
    if (rst)               return 8'b0000_0000;
    if (req && !rdy)       return 8'b0000_0011;
    if (br)                return 8'b1111_1110;
    if (lu)                return 8'b0001_1110;
    if (!imem)             return 8'b0111_0110;
    return 8'b1101_0110;
  endfunction

  function automatic logic [7:0] dut_ctrl();
    return {bus.PCWrite, bus.IF_IDWrite, bus.IF_IDFlush, bus.ID_EXWrite,
            bus.ID_EXFlush, bus.EX_MEMWrite, bus.MEM_WBWrite, bus.MEM_WBFlush};
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive, predict, compare controls at negedge, compare state after edge.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                      input logic u2, input logic [4:0] exrd, input logic mr,
                      input logic br, input logic req, input logic rdy, input logic imem);
    logic [7:0] e;
    logic [7:0] got;
    logic       rst_now;
    logic       br_fire;
    bus.ID_rs1 = rs1; bus.ID_rs2 = rs2; bus.ID_UsesRs1 = u1; bus.ID_UsesRs2 = u2;
    bus.EX_rd = exrd; bus.EX_MemRead = mr; bus.EX_BranchTaken = br;
    bus.MEM_MemReq = req; bus.MEM_MemReady = rdy; bus.IF_ImemReady = imem;
    rst_now = reset;
    e = model_ctrl(rst_now, rs1, rs2, u1, u2, exrd, mr, br, req, rdy, imem);
    exp_q.push_back(e);
    @(negedge clk);
    got = dut_ctrl();
    if (exp_q.size() == 0) begin
      check("ctrl_queue_empty", 32'd1, 32'd0);
    end else begin
      check("ctrl", {24'd0, got}, {24'd0, exp_q.pop_front()});
    end
    @(posedge clk);
    br_fire = !rst_now && br && !(req && !rdy);
    if (rst_now) begin
      m_stall = '0; m_flush = '0; m_dwait = 1'b0; m_wait = 0; m_err = 1'b0;
    end else begin
      if (!e[7] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (br_fire && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
      m_wait = m_dwait ? m_wait + 1 : 0;
      if (m_wait >= TMO) m_err = 1'b1;
      m_dwait = m_dwait ? !rdy : (req && !rdy);
    end
    #1;
    check("stall_cnt", bus.StallCycles, m_stall);
    check("flush_cnt", bus.FlushCount, m_flush);
    check("state", {31'd0, bus.dbg_state}, {31'd0, m_dwait});
    check("tmo_err", {31'd0, bus.DmemTimeoutErr}, {31'd0, m_err});
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) idle();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.ID_rs1 = '0; bus.ID_rs2 = '0; bus.ID_UsesRs1 = 1'b0; bus.ID_UsesRs2 = 1'b0;
    bus.EX_rd = '0; bus.EX_MemRead = 1'b0; bus.EX_BranchTaken = 1'b0;
    bus.MEM_MemReq = 1'b0; bus.MEM_MemReady = 1'b0; bus.IF_ImemReady = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);
    check("reset_stall", bus.StallCycles, 32'd0);

    // Load x5 in EX, add x6,x5,x1 in ID: one bubble, then clear.
    step(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    check("loaduse_stall_cnt", bus.StallCycles, 32'd1);

    // Load to x0 never stalls.
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // rs2 match but rs2 unused: no stall.
    step(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // rs2 match used: stall.
    step(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Branch with imem wait and load-use: redirect wins.
    step(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("branch_flush_cnt", bus.FlushCount, 32'd1);
    check("branch_stall_cnt", bus.StallCycles, 32'd2);

    // Imem wait alone.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Ready without request has no effect.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Dmem wait 3 cycles with branch held, release on the fourth.
    do_reset(1);
    repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("dwait_state", {31'd0, bus.dbg_state}, 32'd1);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("dwait_release_stall", bus.StallCycles, 32'd3);
    check("dwait_release_flush", bus.FlushCount, 32'd1);
    check("dwait_release_state", {31'd0, bus.dbg_state}, 32'd0);

    // Watchdog: never ready -> error after TMO DWAIT cycles, sticky.
    repeat (TMO) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("tmo_not_yet", {31'd0, bus.DmemTimeoutErr}, 32'd0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("tmo_set", {31'd0, bus.DmemTimeoutErr}, 32'd1);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle();
    check("tmo_sticky", {31'd0, bus.DmemTimeoutErr}, 32'd1);

    // Reset while in DWAIT.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    check("rst_dwait_state", {31'd0, bus.dbg_state}, 32'd0);
    check("rst_dwait_err", {31'd0, bus.DmemTimeoutErr}, 32'd0);
    check("rst_dwait_stall", bus.StallCycles, 32'd0);
    idle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0));
      if (i == 200) do_reset(1);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
